posit_result_packer_es3: RTL and testbench
==========================================

Name: posit_result_packer_es3

Overview:
- Downstream of the ES=3 sum normaliser; consumes its 32-bit posit plus inf/zero flags, one result per handshake.
- Packs consecutive results into 512-bit lines (16 lanes) for the host write path.
- Flushes partial lines on a last marker and keeps saturating inf/zero statistics.
- Elastic: one pack buffer plus one output line register, so input stalls only while a complete line waits for the output register to free.

Parameters:
NBITS, 32, posit width (per lane)
LANES, 16, posits per output line
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input result valid
in_ready  out  1  packer can accept a result this cycle
in_posit  in  NBITS  normalised posit (result of the normaliser)
in_inf  in  1  result is NaR/infinity
in_zero  in  1  result is zero
in_last  in  1  final result of a batch; forces line flush
out_valid  out  1  output line valid
out_ready  in  1  downstream accepts line
out_data  out  NBITS*LANES  packed line; lane i at bits [NBITS*i+NBITS-1 : NBITS*i]
out_keep  out  LANES  bit i set when lane i holds a real result
out_last  out  1  line closes a batch
inf_count  out  CNT_W  number of accepted results with in_inf=1 (saturating)
zero_count  out  CNT_W  number of accepted results with in_zero=1 (saturating)
line_count  out  CNT_W  number of lines handed off (out_valid&out_ready), saturating

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high. On reset: out_valid=0, out_data=0, out_keep=0, out_last=0, all counters 0, lane index 0, pack buffer cleared, state FILL. Reset mid-line discards the partial line and any held or pending output line.
- Accept = in_valid & in_ready. in_ready=1 exactly in state FILL; not combinationally dependent on in_valid.
- Packing: the first accepted result of a line goes to lane 0, then lane 1, and so on. Lane index is log2(LANES) bits; it increments per accept and returns to 0 when a line closes. Posit is stored verbatim; the NaR pattern 0x80000000 passes unmodified.
- Line closes on the accept where lane index == LANES-1, or on any accept with in_last=1, whichever comes first.
  - keep = ones for lanes 0..index; unused lanes are zero.
  - last = in_last of the closing result.
- Output slot free = !out_valid | out_ready (registered out_valid).
- FSM states:
  - FILL:
    - Line closes and slot free: line loads into the output register next edge. out_valid=1 at t+1 after the closing accept, so latency is 1 cycle. Stay FILL.
    - Line closes and slot busy: line stays in the pack buffer; go HOLD.
  - HOLD: in_ready=0. When the slot frees (out_valid&out_ready), the held line loads into the output register on that edge and the state returns to FILL. in_ready=1 on the next cycle.
- Output register holds stable (data/keep/last) while out_valid & !out_ready. On out_valid&out_ready with no new line, out_valid drops to 0 next edge. Back-to-back lines sustain one line per LANES cycles with no bubble on the input.
- in_last on an empty line (index 0) produces a line with keep=0x0001.
- No empty lines are ever emitted.
- Counters:
  - inf_count increments per accepted result with in_inf=1. zero_count increments per accepted result with in_zero=1. Flags are mutually exclusive by construction.
  - line_count increments on each output handshake.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Inputs are ignored when !in_ready; no counter changes on unaccepted cycles.

Decomposition:
- Add to posit_defines_es3: LANES_ES3=16, LINE_WIDTH_ES3=NBITS*LANES_ES3, and a line_t struct {data, keep, last}.
- One natural sub-module: posit_sat_counter (width param, increment, synchronous reset, saturating), instantiated three times.
- FSM and pack buffer stay in the top module.

Test Plan:
- Stream 16 results 0x40000000..0x4000000F, out_ready=1 → one line at cycle after 16th accept. Lane0=0x40000000, lane15=0x4000000F, keep=0xFFFF, last=0; line_count=1.
- 5 results with in_last on the 5th → keep=0x001F, out_last=1, lanes 5..15 =0; next result lands in lane 0.
- out_ready=0, send 32 results → first line held on out_data, in_ready drops after accept 32. Then out_ready=1 for 1 cycle → second line appears next cycle, in_ready=1 the following cycle, no data lost.
- Mix: 3 results with in_inf=1 (0x80000000), 4 with in_zero=1 (0x00000000) → inf_count=3, zero_count=4, NaR lanes read 0x80000000.
- Force inf_count to near saturation (CNT_W=4 build): 20 inf results → inf_count stays 15.
- Assert reset after 7 accepts and while a line is held → out_valid=0, counters 0. Next 16 accepts form a fresh line starting at lane 0.

Source files
------------

// File: rtl/posit_defines_es3_pkg.sv
// Shared constants and the output line type for the ES=3 posit result path.
package posit_defines_es3;

  localparam int NBITS_ES3      = 32;
  localparam int LANES_ES3      = 16;
  localparam int LINE_WIDTH_ES3 = NBITS_ES3 * LANES_ES3;

  typedef struct packed {
    logic [LINE_WIDTH_ES3-1:0] data;
    logic [LANES_ES3-1:0]      keep;
    logic                      last;
  } line_t;

endpackage

// File: rtl/posit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module posit_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/posit_result_packer_es3.sv
// Packs normalised posit results into LANES-wide lines with one pack buffer
// plus one output register; tracks saturating inf/zero/line statistics.
module posit_result_packer_es3
  import posit_defines_es3::*;
#(
  parameter int NBITS = NBITS_ES3,
  parameter int LANES = LANES_ES3,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBITS-1:0]       in_posit,
  input  logic                   in_inf,
  input  logic                   in_zero,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBITS*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last,
  output logic [CNT_W-1:0]       inf_count,
  output logic [CNT_W-1:0]       zero_count,
  output logic [CNT_W-1:0]       line_count
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  typedef struct packed {
    logic [NBITS*LANES-1:0] data;
    logic [LANES-1:0]       keep;
    logic                   last;
  } pack_line_t;

  state_t           r_state;
  logic [NBITS-1:0] r_buf [LANES];
  logic [IDX_W-1:0] r_idx;
  logic [LANES-1:0] r_hold_keep;
  logic             r_hold_last;
  pack_line_t       r_out_line;
  logic             r_out_valid;

  logic                   w_accept;
  logic                   w_close;
  logic                   w_slot_free;
  logic                   w_load_fill;
  logic                   w_load_hold;
  logic [NBITS*LANES-1:0] w_fill_data;
  logic [LANES-1:0]       w_fill_keep;
  logic [NBITS*LANES-1:0] w_hold_data;
  pack_line_t             w_fill_line;
  pack_line_t             w_hold_line;

  assign in_ready    = (r_state == S_FILL);
  assign w_accept    = in_valid & in_ready;
  assign w_close     = w_accept & ((r_idx == LAST_IDX) | in_last);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_load_fill = (r_state == S_FILL) & w_close & w_slot_free;
  assign w_load_hold = (r_state == S_HOLD) & w_slot_free;

  // The closing result bypasses the buffer; lanes past it read as zero so
  // stale data from an earlier line never leaks out.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [IDX_W-1:0] LANE = IDX_W'(gi);
    assign w_fill_keep[gi] = (LANE <= r_idx);
    assign w_fill_data[NBITS*gi +: NBITS] = (LANE == r_idx) ? in_posit :
                                            (LANE < r_idx)  ? r_buf[gi] : '0;
    assign w_hold_data[NBITS*gi +: NBITS] = r_hold_keep[gi] ? r_buf[gi] : '0;
  end

  assign w_fill_line = '{data: w_fill_data, keep: w_fill_keep, last: in_last};
  assign w_hold_line = '{data: w_hold_data, keep: r_hold_keep, last: r_hold_last};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_idx] <= in_posit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
      r_out_line  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= w_close ? '0 : r_idx + IDX_W'(1);
      end
      case (r_state)
        S_FILL: begin
          if (w_close && !w_slot_free) begin
            r_hold_keep <= w_fill_keep;
            r_hold_last <= in_last;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_slot_free) begin
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
      if (w_load_fill) begin
        r_out_line  <= w_fill_line;
        r_out_valid <= 1'b1;
      end else if (w_load_hold) begin
        r_out_line  <= w_hold_line;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_line.data;
  assign out_keep  = r_out_line.keep;
  assign out_last  = r_out_line.last;

  posit_sat_counter #(.W(CNT_W)) u_inf_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_accept & in_inf),
    .o_count(inf_count)
  );

  posit_sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_accept & in_zero),
    .o_count(zero_count)
  );

  posit_sat_counter #(.W(CNT_W)) u_line_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (r_out_valid & out_ready),
    .o_count(line_count)
  );

endmodule

// File: tb/tb_posit_result_packer_es3.sv
// Directed bench with a line-level reference model; a 4-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_posit_result_packer_es3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_posit;
  logic         in_inf;
  logic         in_zero;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [15:0]  out_keep;
  logic         out_last;
  logic [31:0]  inf_count;
  logic [31:0]  zero_count;
  logic [31:0]  line_count;

  logic         s_in_ready;
  logic         s_out_valid;
  logic [511:0] s_out_data;
  logic [15:0]  s_out_keep;
  logic         s_out_last;
  logic [3:0]   s_inf_count;
  logic [3:0]   s_zero_count;
  logic [3:0]   s_line_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  posit_result_packer_es3 u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_posit(in_posit), .in_inf(in_inf), .in_zero(in_zero), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .inf_count(inf_count),
    .zero_count(zero_count), .line_count(line_count)
  );

  posit_result_packer_es3 #(.CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_posit(in_posit), .in_inf(in_inf), .in_zero(in_zero), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_keep(s_out_keep), .out_last(s_out_last), .inf_count(s_inf_count),
    .zero_count(s_zero_count), .line_count(s_line_count)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a list of lanes collected so far, at most one closed line
  // waiting for the output slot, and the line currently presented downstream.
  logic [31:0]  m_cur [16];
  int           m_n;
  logic [511:0] m_out_data, m_pend_data;
  logic [15:0]  m_out_keep, m_pend_keep;
  logic         m_out_last, m_pend_last;
  logic         m_out_valid, m_pend_valid;
  longint       m_inf, m_zero, m_lines;
  bit           started = 0;

  function automatic longint sat(input longint v, input longint cap);
    return (v > cap) ? cap : v;
  endfunction

  always @(posedge clk) begin
    bit acc, free;
    logic [511:0] d;
    int k;
    if (reset) begin
      m_n = 0; m_out_valid = 0; m_pend_valid = 0;
      m_out_data = '0; m_out_keep = '0; m_out_last = 0;
      m_inf = 0; m_zero = 0; m_lines = 0;
    end else begin
      acc  = in_valid && !m_pend_valid;
      free = !m_out_valid || out_ready;
      if (m_out_valid && out_ready) begin
        m_lines = sat(m_lines + 1, 64'hFFFF_FFFF);
        m_out_valid = 0;
      end
      if (m_pend_valid && free) begin
        m_out_data = m_pend_data; m_out_keep = m_pend_keep;
        m_out_last = m_pend_last; m_out_valid = 1; m_pend_valid = 0;
      end else if (acc) begin
        if (in_inf)  m_inf  = sat(m_inf + 1, 64'hFFFF_FFFF);
        if (in_zero) m_zero = sat(m_zero + 1, 64'hFFFF_FFFF);
        m_cur[m_n] = in_posit;
        m_n++;
        if (m_n == 16 || in_last) begin
          d = '0;
          for (int i = 0; i < m_n; i++) d[i*32 +: 32] = m_cur[i];
          k = (1 << m_n) - 1;
          if (free) begin
            m_out_data = d; m_out_keep = k[15:0]; m_out_last = in_last; m_out_valid = 1;
          end else begin
            m_pend_data = d; m_pend_keep = k[15:0]; m_pend_last = in_last; m_pend_valid = 1;
          end
          m_n = 0;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 512'(in_ready), 512'(!m_pend_valid));
      chk("out_valid", 512'(out_valid), 512'(m_out_valid));
      if (m_out_valid) begin
        chk("out_data", out_data, m_out_data);
        chk("out_keep", 512'(out_keep), 512'(m_out_keep));
        chk("out_last", 512'(out_last), 512'(m_out_last));
      end
      chk("inf_count", 512'(inf_count), 512'(m_inf));
      chk("zero_count", 512'(zero_count), 512'(m_zero));
      chk("line_count", 512'(line_count), 512'(m_lines));
      chk("small_inf", 512'(s_inf_count), 512'(sat(m_inf, 15)));
      chk("small_zero", 512'(s_zero_count), 512'(sat(m_zero, 15)));
      chk("small_lines", 512'(s_line_count), 512'(sat(m_lines, 15)));
    end
  end

  task automatic send(input logic [31:0] p, input logic inf = 0,
                      input logic zero = 0, input logic last = 0);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_posit = p; in_inf = inf; in_zero = zero; in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 512'(in_ready), 512'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0; in_inf = 0; in_zero = 0; in_last = 0;
  endtask

  task automatic wait_line(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({name, "_timeout"}, 512'(out_valid), 512'(1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1; in_valid = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_posit = '0; in_inf = 0; in_zero = 0;
    in_last = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_out_data", out_data, 512'(0));
    chk("reset_inf", 512'(inf_count), 512'(0));
    reset = 0;

    // Full line, downstream always ready.
    for (int i = 0; i < 16; i++) send(32'h4000_0000 + 32'(i));
    idle();
    wait_line("t1");
    chk("t1_lane0", 512'(out_data[31:0]), 512'(32'h4000_0000));
    chk("t1_lane15", 512'(out_data[511:480]), 512'(32'h4000_000F));
    chk("t1_keep", 512'(out_keep), 512'(16'hFFFF));
    chk("t1_last", 512'(out_last), 512'(0));
    @(negedge clk);
    chk("t1_line_count", 512'(line_count), 512'(1));

    // Short batch, then a single-result batch on an empty line.
    for (int i = 0; i < 5; i++) send(32'h50 + 32'(i), 0, 0, i == 4);
    idle();
    wait_line("t2");
    chk("t2_keep", 512'(out_keep), 512'(16'h001F));
    chk("t2_last", 512'(out_last), 512'(1));
    chk("t2_lane4", 512'(out_data[159:128]), 512'(32'h54));
    chk("t2_lane5", 512'(out_data[191:160]), 512'(0));
    send(32'h60, 0, 0, 1);
    idle();
    wait_line("t2b");
    chk("t2b_keep", 512'(out_keep), 512'(16'h0001));
    chk("t2b_lane0", 512'(out_data[31:0]), 512'(32'h60));

    // Backpressure: second line parks in the pack buffer.
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 32; i++) send(32'h7000 + 32'(i));
    idle();
    chk("t3_held_lane0", 512'(out_data[31:0]), 512'(32'h7000));
    chk("t3_in_ready_low", 512'(in_ready), 512'(0));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("t3_second_valid", 512'(out_valid), 512'(1));
    chk("t3_second_lane0", 512'(out_data[31:0]), 512'(32'h7010));
    chk("t3_second_lane15", 512'(out_data[511:480]), 512'(32'h701F));
    chk("t3_in_ready_back", 512'(in_ready), 512'(1));
    @(negedge clk);
    out_ready = 1;

    // NaR and zero statistics.
    for (int i = 0; i < 3; i++) send(32'h8000_0000, 1, 0, 0);
    for (int i = 0; i < 4; i++) send(32'h0, 0, 1, i == 3);
    idle();
    wait_line("t4");
    chk("t4_nar_lane0", 512'(out_data[31:0]), 512'(32'h8000_0000));
    chk("t4_nar_lane2", 512'(out_data[95:64]), 512'(32'h8000_0000));
    chk("t4_inf", 512'(inf_count), 512'(3));
    chk("t4_zero", 512'(zero_count), 512'(4));

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) send(32'h8000_0000, 1, 0, i == 19);
    idle();
    repeat (3) @(negedge clk);
    chk("t5_small_inf_sat", 512'(s_inf_count), 512'(15));
    chk("t5_big_inf", 512'(inf_count), 512'(23));

    // Reset while a line is held, then mid-line.
    out_ready = 0;
    for (int i = 0; i < 32; i++) send(32'h9000 + 32'(i));
    idle();
    chk("t6_held", 512'(in_ready), 512'(0));
    pulse_reset();
    out_ready = 1;
    chk("t6_rst_valid", 512'(out_valid), 512'(0));
    chk("t6_rst_inf", 512'(inf_count), 512'(0));
    for (int i = 0; i < 7; i++) send(32'hA000 + 32'(i));
    pulse_reset();
    chk("t6_rst2_line_count", 512'(line_count), 512'(0));
    for (int i = 0; i < 16; i++) send(32'h1000 + 32'(i));
    idle();
    wait_line("t6");
    chk("t6_lane0", 512'(out_data[31:0]), 512'(32'h1000));
    chk("t6_keep", 512'(out_keep), 512'(16'hFFFF));
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
